// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads one- or two-byte instructions from
// program memory and presents them to execute over a valid/ready handshake.
module instruction_fetch #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] pm_addr,
    input  logic [DATA_W-1:0] pm_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [3:0]        opcode,
    output logic [3:0]        operand,
    output logic [DATA_W-1:0] imm,
    output logic              has_imm,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr
);

    // Opcodes that carry an immediate byte after the opcode byte.
    localparam logic [3:0] OP_LDI = 4'b0010;
    localparam logic [3:0] OP_JZ  = 4'b1101;

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_IMM = 2'd1,
        HOLD      = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic                has_imm_q, has_imm_d;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;

    logic [3:0]          fetched_op;
    logic                fetched_two_byte;
    logic [ADDR_W-1:0]   pc_inc;

    assign fetched_op       = pm_data[DATA_W-1 -: 4];
    assign fetched_two_byte = (fetched_op == OP_LDI) || (fetched_op == OP_JZ);
    // Natural width truncation gives the modulo-2^ADDR_W wrap.
    assign pc_inc           = pc_q + ADDR_W'(1);

    // State and instruction registers; reset discards any partial fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH_OP;
            pc_q       <= ADDR_W'(RESET_PC);
            ir_q       <= '0;
            imm_q      <= '0;
            has_imm_q  <= 1'b0;
            valid_q    <= 1'b0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            imm_q      <= imm_d;
            has_imm_q  <= has_imm_d;
            valid_q    <= valid_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // Next-state logic: fetch opcode, optionally fetch immediate, then hold
    // until execute accepts; redirect is only honoured on that acceptance.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        imm_d      = imm_q;
        has_imm_d  = has_imm_q;
        valid_d    = valid_q;
        instr_pc_d = instr_pc_q;
        case (state_q)
            FETCH_OP: begin
                ir_d       = pm_data;
                instr_pc_d = pc_q;
                pc_d       = pc_inc;
                if (fetched_two_byte) begin
                    state_d = FETCH_IMM;
                end else begin
                    has_imm_d = 1'b0;
                    imm_d     = '0;
                    valid_d   = 1'b1;
                    state_d   = HOLD;
                end
            end
            FETCH_IMM: begin
                imm_d     = pm_data;
                has_imm_d = 1'b1;
                pc_d      = pc_inc;
                valid_d   = 1'b1;
                state_d   = HOLD;
            end
            HOLD: begin
                if (valid_q && instr_ready) begin
                    valid_d = 1'b0;
                    state_d = FETCH_OP;
                    if (redirect_valid) begin
                        pc_d = redirect_addr;
                    end
                end
            end
            default: begin
                state_d = FETCH_OP;
                valid_d = 1'b0;
            end
        endcase
    end

    assign pm_addr     = pc_q;
    assign instr_valid = valid_q;
    assign opcode      = ir_q[DATA_W-1 -: 4];
    assign operand     = ir_q[3:0];
    assign imm         = imm_q;
    assign has_imm     = has_imm_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed instruction table, hand-written
// stall/redirect/async-reset sequences, and a randomized run against a
// transaction-level reference model.
module tb_instruction_fetch;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] pm_addr;
    logic [7:0] pm_data;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic [7:0] imm;
    logic       has_imm;
    logic [4:0] instr_pc;
    logic       redirect_valid;
    logic [4:0] redirect_addr;

    logic [7:0] mem [32];
    assign pm_data = mem[pm_addr];

    int checks = 0;
    int errors = 0;

    instruction_fetch #(.ADDR_W(5), .DATA_W(8), .RESET_PC(0)) dut (
        .clk            (clk),
        .reset          (reset),
        .pm_addr        (pm_addr),
        .pm_data        (pm_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .opcode         (opcode),
        .operand        (operand),
        .imm            (imm),
        .has_imm        (has_imm),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic is_two_byte(input logic [7:0] b);
        return (b[7:4] == 4'h2) || (b[7:4] == 4'hD);
    endfunction

    typedef struct {
        logic       rv;
        logic [4:0] ra;
        logic [3:0] op;
        logic [3:0] opd;
        logic [7:0] imm;
        logic       hi;
        logic [4:0] pc;
        int         lat;
    } vec_t;

    vec_t tbl [16];

    // Wait (bounded) for instr_valid; returns number of negedges waited.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (instr_valid !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        if (instr_valid !== 1'b1) chk("valid_timeout", 32'(instr_valid), 1);
    endtask

    // Transaction-level model state for the random run.
    logic [4:0] m_pc;
    int         m_wait;

    task automatic model_step;
        logic [7:0] b0;
        logic       hi;
        logic       exp_v;
        logic [4:0] end_pc;
        logic       rdy, rv;
        logic [4:0] ra;
        b0     = mem[m_pc];
        hi     = is_two_byte(b0);
        exp_v  = (m_wait >= 1 + int'(hi));
        end_pc = m_pc + 5'd1 + 5'(hi);
        chk("rnd_valid", 32'(instr_valid), 32'(exp_v));
        if (exp_v) begin
            chk("rnd_pm_addr", 32'(pm_addr), 32'(end_pc));
            chk("rnd_opcode", 32'(opcode), 32'(b0[7:4]));
            chk("rnd_operand", 32'(operand), 32'(b0[3:0]));
            chk("rnd_has_imm", 32'(has_imm), 32'(hi));
            chk("rnd_imm", 32'(imm), hi ? 32'(mem[5'(m_pc + 5'd1)]) : 32'd0);
            chk("rnd_instr_pc", 32'(instr_pc), 32'(m_pc));
        end else begin
            chk("rnd_pm_addr", 32'(pm_addr), 32'(5'(m_pc + 5'(m_wait))));
        end
        rdy = ($urandom_range(0, 2) != 0);
        rv  = ($urandom_range(0, 3) == 0);
        ra  = 5'($urandom_range(0, 31));
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_addr  = ra;
        if (exp_v && rdy) begin
            m_pc   = rv ? ra : end_pc;
            m_wait = 0;
        end else if (!exp_v) begin
            m_wait++;
        end
    endtask

    initial begin
        int         cyc;
        logic [4:0] exp_next;

        reset          = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[0]  = 8'h10; mem[1]  = 8'h41; mem[2]  = 8'h20; mem[3]  = 8'h01;
        mem[4]  = 8'h40; mem[5]  = 8'h60; mem[21] = 8'h37; mem[22] = 8'h00;
        mem[23] = 8'hD0; mem[24] = 8'h15; mem[25] = 8'h5A; mem[30] = 8'h90;
        mem[31] = 8'h20;

        //          rv  ra     op     opd    imm    hi  pc     lat
        tbl[0]  = '{1'b0, 5'd0,  4'h1, 4'h0, 8'h00, 1'b0, 5'd0,  1};
        tbl[1]  = '{1'b0, 5'd0,  4'h4, 4'h1, 8'h00, 1'b0, 5'd1,  1};
        tbl[2]  = '{1'b0, 5'd0,  4'h2, 4'h0, 8'h01, 1'b1, 5'd2,  2};
        tbl[3]  = '{1'b1, 5'd23, 4'h4, 4'h0, 8'h00, 1'b0, 5'd4,  1};
        tbl[4]  = '{1'b1, 5'd21, 4'hD, 4'h0, 8'h15, 1'b1, 5'd23, 2};
        tbl[5]  = '{1'b0, 5'd0,  4'h3, 4'h7, 8'h00, 1'b0, 5'd21, 1};
        tbl[6]  = '{1'b0, 5'd0,  4'h0, 4'h0, 8'h00, 1'b0, 5'd22, 1};
        tbl[7]  = '{1'b0, 5'd0,  4'hD, 4'h0, 8'h15, 1'b1, 5'd23, 2};
        tbl[8]  = '{1'b1, 5'd30, 4'h5, 4'hA, 8'h00, 1'b0, 5'd25, 1};
        tbl[9]  = '{1'b0, 5'd0,  4'h9, 4'h0, 8'h00, 1'b0, 5'd30, 1};
        tbl[10] = '{1'b0, 5'd0,  4'h2, 4'h0, 8'h07, 1'b1, 5'd31, 2};
        tbl[11] = '{1'b0, 5'd0,  4'h4, 4'h1, 8'h00, 1'b0, 5'd1,  1};
        tbl[12] = '{1'b1, 5'd2,  4'h2, 4'h0, 8'h01, 1'b1, 5'd2,  2};
        tbl[13] = '{1'b1, 5'd4,  4'h2, 4'h0, 8'h01, 1'b1, 5'd2,  2};
        tbl[14] = '{1'b1, 5'd5,  4'h4, 4'h0, 8'h00, 1'b0, 5'd4,  1};
        tbl[15] = '{1'b0, 5'd0,  4'h6, 4'h0, 8'h00, 1'b0, 5'd5,  1};

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_pm_addr", 32'(pm_addr), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_opcode", 32'(opcode), 0);
        chk("rst_imm", 32'(imm), 0);
        chk("rst_has_imm", 32'(has_imm), 0);
        chk("rst_instr_pc", 32'(instr_pc), 0);
        reset       = 1'b0;
        instr_ready = 1'b1;

        // Directed instruction table with constant instr_ready.
        for (int i = 0; i < 16; i++) begin
            // The wrap entry needs address 0 to hold its immediate byte.
            if (i == 1) mem[0] = 8'h07;
            wait_valid(cyc);
            chk($sformatf("t%0d_latency", i), 32'(cyc), 32'(tbl[i].lat));
            chk($sformatf("t%0d_opcode", i), 32'(opcode), 32'(tbl[i].op));
            chk($sformatf("t%0d_operand", i), 32'(operand), 32'(tbl[i].opd));
            chk($sformatf("t%0d_imm", i), 32'(imm), 32'(tbl[i].imm));
            chk($sformatf("t%0d_has_imm", i), 32'(has_imm), 32'(tbl[i].hi));
            chk($sformatf("t%0d_instr_pc", i), 32'(instr_pc), 32'(tbl[i].pc));
            redirect_valid = tbl[i].rv;
            redirect_addr  = tbl[i].ra;
            exp_next = tbl[i].rv ? tbl[i].ra : 5'(tbl[i].pc + 5'd1 + 5'(tbl[i].hi));
            @(negedge clk);
            redirect_valid = 1'b0;
            chk($sformatf("t%0d_next_pm_addr", i), 32'(pm_addr), 32'(exp_next));
            chk($sformatf("t%0d_valid_drop", i), 32'(instr_valid), 0);
            $display("table %0d: pc=%0d op=%h opd=%h imm=%h has_imm=%0d next=%0d",
                     i, instr_pc, opcode, operand, imm, has_imm, pm_addr);
        end

        // Stall with redirect noise: nothing moves for 5 cycles.
        instr_ready = 1'b0;
        wait_valid(cyc);
        for (int k = 0; k < 5; k++) begin
            redirect_valid = 1'b1;
            redirect_addr  = 5'd17;
            @(negedge clk);
            chk("stall_valid", 32'(instr_valid), 1);
            chk("stall_pm_addr", 32'(pm_addr), 7);
            chk("stall_instr_pc", 32'(instr_pc), 6);
            chk("stall_opcode", 32'(opcode), 0);
        end
        $display("stall: held instr_pc=%0d pm_addr=%0d for 5 cycles", instr_pc, pm_addr);
        // Release with a redirect to 21; exactly one handshake.
        instr_ready    = 1'b1;
        redirect_addr  = 5'd21;
        @(negedge clk);
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        chk("release_valid", 32'(instr_valid), 0);
        chk("release_pm_addr", 32'(pm_addr), 21);
        @(negedge clk);
        chk("after_release_instr_pc", 32'(instr_pc), 21);
        @(negedge clk);
        chk("single_handshake_valid", 32'(instr_valid), 1);
        chk("single_handshake_pm_addr", 32'(pm_addr), 22);
        $display("release: one handshake, refetched pc=%0d", instr_pc);

        // Redirect to 2, then reset asynchronously while fetching the immediate.
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 5'd2;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_pm_addr", 32'(pm_addr), 3);
        chk("pre_reset_opcode", 32'(opcode), 2);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(instr_valid), 0);
        chk("async_rst_pm_addr", 32'(pm_addr), 0);
        chk("async_rst_opcode", 32'(opcode), 0);
        chk("async_rst_instr_pc", 32'(instr_pc), 0);
        @(negedge clk);
        reset = 1'b0;
        wait_valid(cyc);
        chk("restart_latency", 32'(cyc), 1);
        chk("restart_instr_pc", 32'(instr_pc), 0);
        chk("restart_operand", 32'(operand), 7);
        $display("async reset: restarted at pc=%0d op=%h opd=%h", instr_pc, opcode, operand);

        // Randomized runs against the transaction-level model.
        for (int r = 0; r < 2; r++) begin
            reset = 1'b1;
            for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
            @(negedge clk);
            reset  = 1'b0;
            m_pc   = 5'd0;
            m_wait = 0;
            for (int c = 0; c < 3000; c++) begin
                model_step();
                @(negedge clk);
            end
            $display("random run %0d: 3000 cycles, checks so far %0d", r, checks);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
